// File: rtl/cache_mem_port.sv
// cache_mem_port: per-word line transfer engine (writeback from victim buffer, fill into data array).
// Define CACHE_MEM_PORT_TIMEOUT_EN to add a handshake watchdog that aborts with done+err.
module cache_mem_port #(
   parameter int ADDR_W     = 32,
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                          clk,
   input  logic                          rst_b,
   input  logic                          req_wb,
   input  logic                          req_fill,
   input  logic [ADDR_W-1:0]             wb_addr,
   input  logic [ADDR_W-1:0]             fill_addr,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic [$clog2(LINE_WORDS)-1:0] lb_idx,
   input  logic [WORD_W-1:0]             lb_word,
   output logic                          fill_we,
   output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
   output logic [WORD_W-1:0]             fill_word,
   output logic                          m_valid,
   output logic                          m_we,
   output logic [ADDR_W-1:0]             m_addr,
   output logic [WORD_W-1:0]             m_wdata,
   input  logic                          m_ready,
   input  logic                          m_rvalid,
   input  logic [WORD_W-1:0]             m_rdata
);
   localparam int IW  = $clog2(LINE_WORDS);
   localparam int BW  = WORD_W / 8;
   localparam int OFF = $clog2(LINE_WORDS * BW);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));

   if (WORD_W % 8 != 0 || LINE_WORDS < 2 || (LINE_WORDS & (LINE_WORDS - 1)) != 0 || TIMEOUT < 2) begin : g_bad_cfg
      $error("cache_mem_port: unsupported parameter set");
   end

   typedef enum logic [2:0] {IDLE, WB_CMD, RD_CMD, RD_WAIT, DONE} state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     beat, beat_nxt;
   logic [ADDR_W-1:0] wb_base, fill_base;
   logic              pend, pend_nxt;

`ifdef CACHE_MEM_PORT_TIMEOUT_EN
   localparam logic [15:0] WD_LIM = 16'(TIMEOUT - 2);
   logic [15:0] wd;
   logic        err_r;
   logic        stall, wd_hit;
   assign stall  = ((state == WB_CMD || state == RD_CMD) && !m_ready) || (state == RD_WAIT && !m_rvalid);
   assign wd_hit = stall && wd == WD_LIM;
   assign err    = state == DONE && err_r;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      pend_nxt  = pend;
      fill_we   = 1'b0;
      case (state)
         IDLE: begin
            beat_nxt  = '0;
            pend_nxt  = req_wb && req_fill;
            state_nxt = req_wb ? WB_CMD : req_fill ? RD_CMD : IDLE;
         end
         WB_CMD: if (m_ready) begin
            beat_nxt = beat + 1'b1;
            if (&beat) begin
               state_nxt = pend ? RD_CMD : DONE;
               pend_nxt  = 1'b0;
            end
         end
         RD_CMD: state_nxt = m_ready ? RD_WAIT : RD_CMD;
         RD_WAIT: if (m_rvalid) begin
            fill_we   = 1'b1;
            beat_nxt  = beat + 1'b1;
            state_nxt = &beat ? DONE : RD_CMD;
         end
         default: state_nxt = IDLE;
      endcase
`ifdef CACHE_MEM_PORT_TIMEOUT_EN
      if (wd_hit) state_nxt = DONE;
`endif
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= IDLE;
         beat      <= '0;
         pend      <= 1'b0;
         wb_base   <= '0;
         fill_base <= '0;
      end else begin
         state <= state_nxt;
         beat  <= beat_nxt;
         pend  <= pend_nxt;
         if (state == IDLE && (req_wb || req_fill)) begin
            wb_base   <= wb_addr & LINE_MASK;
            fill_base <= fill_addr & LINE_MASK;
         end
      end
   end

`ifdef CACHE_MEM_PORT_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wd    <= '0;
         err_r <= 1'b0;
      end else begin
         wd    <= stall ? wd + 16'd1 : '0;
         err_r <= wd_hit;
      end
   end
`endif

   assign busy      = state != IDLE;
   assign done      = state == DONE;
   assign m_valid   = state == WB_CMD || state == RD_CMD;
   assign m_we      = state == WB_CMD;
   assign m_addr    = m_valid ? (m_we ? wb_base : fill_base) + ADDR_W'(beat) * ADDR_W'(BW) : '0;
   assign m_wdata   = m_we ? lb_word : '0;
   assign lb_idx    = m_we ? beat : '0;
   assign fill_idx  = fill_we ? beat : '0;
   assign fill_word = fill_we ? m_rdata : '0;
endmodule
